div_seq_unit: RTL
=================

# div_seq_unit

Multi-cycle sequencer for the M-extension divide/remainder operations of the execute stage. The pipeline hands it one division op per transaction over a valid/ready handshake. It runs a radix-2 restoring shift-subtract datapath for a fixed number of iterations, applies the RISC-V sign and special-case fix-ups, and returns a 64-bit result. It replaces the single-cycle divide path of the ALU; the execute stage stalls while `o_ready` is low or while a result is pending.

## Interface
- `DATA_WIDTH`, 64, operand/result width.
- `WORD_WIDTH`, 32, width of the `*W` variants.
- `CONTROL_WIDTH`, 5, width of the ALU control code.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `i_clk`  in  1  clock; all state changes on its rising edge.
- `i_arst_n`  in  1  asynchronous active-low reset.
- `i_valid`  in  1  request present.
- `o_ready`  out  1  unit idle; a request is accepted on a rising edge where `i_valid & o_ready & ~i_flush`.
- `i_alu_control`  in  CONTROL_WIDTH  op code:
  - DIV=10011, DIVU=10100, REM=10101, REMU=10110
  - DIVW=11000, DIVUW=11001, REMW=11010, REMUW=11011
- `i_src_1`  in  DATA_WIDTH  dividend.
- `i_src_2`  in  DATA_WIDTH  divisor.
- `i_flush`  in  1  pipeline kill; aborts any op in flight.
- `o_valid`  out  1  result available.
- `i_ready`  in  1  consumer accepts the result on an edge where `o_valid & i_ready`.
- `o_result`  out  DATA_WIDTH  quotient or remainder.

## Operation
- States are IDLE, PREP, CALC, FIX and DONE. `o_ready` = (state==IDLE). `o_valid` = (state==DONE).
- IDLE → PREP on accept. Op code and operands are registered at the accept edge; later input changes are ignored.
- **PREP**
  - Word ops: operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops. N = WORD_WIDTH.
  - Full-width ops: N = DATA_WIDTH.
  - Signed ops: absolute values are taken, and quotient sign = sign1^sign2 and remainder sign = sign1 are recorded.
  - Special cases are detected here.
  - PREP → CALC with iteration counter = N−1.
- **CALC**
  - One quotient bit per cycle: shift {rem, quo} left, trial-subtract the divisor, and keep the result if it is non-negative.
  - The counter decrements; CALC → FIX when the counter reaches 0.
- **FIX**
  - Applies the recorded signs via two's-complement negate and selects quotient or remainder.
  - Word ops: bit 31 of the 32-bit result is sign-extended into bits 63:32. This applies to DIVUW/REMUW too.
  - Special-case results override the computed value. FIX → DONE.
- **Special cases**
  - Divisor == 0: quotient = all ones, remainder = dividend (word: 32-bit dividend, sign-extended).
  - Signed overflow (most-negative / −1): quotient = dividend, remainder = 0.
- **DONE**
  - `o_result` is held stable while `i_ready` is low.
  - DONE → IDLE on the `i_ready` edge. A new request cannot be accepted in that same cycle.
- **Flush**: `i_flush` high in any state → IDLE at the next edge. `o_valid` drops with no result delivered. Flush has priority over accept and over the DONE handshake.
- **Illegal op code** on accept: processed as a normal op and returns 0.

## Timing
- Reset values: state=IDLE, `o_ready`=1, `o_valid`=0, `o_result`=0, counter=0, all datapath registers 0.
- Reset asserted mid-operation aborts immediately; no result is produced.
- Latency counts edges from the accept edge to the edge where `o_valid` rises:
  - Normal path: N+2 edges, i.e. 66 for 64-bit ops and 34 for word ops.
  - Early-out path (when `DIV_EARLY_OUT_EN` is defined): 2 edges.
- Throughput: one op per latency + 2 cycles at full consumer readiness, due to the idle cycle after DONE.
- No combinational path from any input to any output. `o_ready`, `o_valid` and `o_result` are decoded from registers only.

## Configuration
- `DIV_EARLY_OUT_EN` defined:
  - Divide-by-zero and signed overflow go PREP → FIX directly, skipping CALC; latency is 2 edges.
  - The FIX-stage override logic remains the single source of special-case values.
- `DIV_EARLY_OUT_EN` undefined:
  - All ops, including special cases, traverse CALC for the full N iterations; latency is N+2.
  - Results are bit-identical to the defined case.

## Test plan
- DIV, src1=−7, src2=2, `i_ready`=1 → `o_result`=0xFFFF_FFFF_FFFF_FFFD, `o_valid` 66 edges after accept. Same operands with REM → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU, src1=0x1234, src2=0 → all ones; REMU on the same operands → 0x1234. Latency 2 with `DIV_EARLY_OUT_EN`, 66 without.
- DIVW, src1=0x0000_0000_8000_0000, src2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_8000_0000; REMW → 0. DIVUW 0xFFFF_FFFE / 1 → 0xFFFF_FFFF_FFFF_FFFE, latency 34.
- Back-pressure: DIVU 100/7 with `i_ready` low for 5 cycles after `o_valid` → `o_result`=14 held stable. `o_ready` stays 0 until one cycle after the `i_ready` handshake.
- `i_flush` at CALC iteration 10 → IDLE next edge, `o_valid` never asserts. A subsequent REM 100/−7 returns 2.
- `i_arst_n` pulsed low mid-CALC → outputs return to reset values asynchronously. The first op after release, DIV 0x10/0x4, returns 4.

Source files
------------

// File: rtl/div_seq_unit_if.sv
// Request/response bundle between the execute stage (master) and div_seq_unit (slave).
// Carries both valid/ready handshakes, the pipeline flush and a debug view of the FSM state.
interface div_seq_unit_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int CONTROL_WIDTH = 5
);
    logic                     i_valid;
    logic                     o_ready;
    logic [CONTROL_WIDTH-1:0] i_alu_control;
    logic [DATA_WIDTH-1:0]    i_src_1;
    logic [DATA_WIDTH-1:0]    i_src_2;
    logic                     i_flush;
    logic                     o_valid;
    logic                     i_ready;
    logic [DATA_WIDTH-1:0]    o_result;
    logic [2:0]               o_state;

    modport master (
        output i_valid, i_alu_control, i_src_1, i_src_2, i_flush, i_ready,
        input  o_ready, o_valid, o_result, o_state
    );

    modport slave (
        input  i_valid, i_alu_control, i_src_1, i_src_2, i_flush, i_ready,
        output o_ready, o_valid, o_result, o_state
    );
endinterface

// File: rtl/div_seq_unit.sv
// Multi-cycle radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU and their *W forms.
// Optional `DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iteration loop.
//
// Handshakes: a request is taken on a rising edge with i_valid & o_ready & ~i_flush;
// a result is taken on a rising edge with o_valid & i_ready & ~i_flush.
module div_seq_unit #(
    parameter int DATA_WIDTH    = 64,
    parameter int WORD_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 5
) (
    input  logic           i_clk,
    input  logic           i_arst_n,
    div_seq_unit_if.slave  bus
);
    localparam int DW    = DATA_WIDTH;
    localparam int WW    = WORD_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH);

    localparam logic [CONTROL_WIDTH-1:0] OP_DIV   = 5'b10011;
    localparam logic [CONTROL_WIDTH-1:0] OP_DIVU  = 5'b10100;
    localparam logic [CONTROL_WIDTH-1:0] OP_REM   = 5'b10101;
    localparam logic [CONTROL_WIDTH-1:0] OP_REMU  = 5'b10110;
    localparam logic [CONTROL_WIDTH-1:0] OP_DIVW  = 5'b11000;
    localparam logic [CONTROL_WIDTH-1:0] OP_DIVUW = 5'b11001;
    localparam logic [CONTROL_WIDTH-1:0] OP_REMW  = 5'b11010;
    localparam logic [CONTROL_WIDTH-1:0] OP_REMUW = 5'b11011;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [CONTROL_WIDTH-1:0] op_q, op_d;
    logic [DW-1:0]            src1_q, src1_d;
    logic [DW-1:0]            src2_q, src2_d;
    logic [DW-1:0]            quo_q, quo_d;
    logic [DW-1:0]            rem_q, rem_d;
    logic [DW-1:0]            dvsr_q, dvsr_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]            result_q, result_d;

    // Op decode; anything outside the table is an unsigned full-width op forced to 0.
    logic is_legal, is_signed, is_rem, is_word;
    always_comb begin
        is_legal  = 1'b1;
        is_signed = 1'b0;
        is_rem    = 1'b0;
        is_word   = 1'b0;
        case (op_q)
            OP_DIV:   is_signed = 1'b1;
            OP_DIVU:  ;
            OP_REM:   begin is_signed = 1'b1; is_rem = 1'b1; end
            OP_REMU:  is_rem = 1'b1;
            OP_DIVW:  begin is_word = 1'b1; is_signed = 1'b1; end
            OP_DIVUW: is_word = 1'b1;
            OP_REMW:  begin is_word = 1'b1; is_signed = 1'b1; is_rem = 1'b1; end
            OP_REMUW: begin is_word = 1'b1; is_rem = 1'b1; end
            default:  is_legal = 1'b0;
        endcase
    end

    // Operand conditioning is derived from the captured operands, so it is stable from PREP to FIX.
    logic [DW-1:0] a_ext, b_ext, a_word_sx, abs_a, abs_b, min_val;
    logic          sign_a, sign_b, div_zero, sgn_ovf;
    always_comb begin
        a_ext     = is_word ? {{(DW-WW){is_signed & src1_q[WW-1]}}, src1_q[WW-1:0]} : src1_q;
        b_ext     = is_word ? {{(DW-WW){is_signed & src2_q[WW-1]}}, src2_q[WW-1:0]} : src2_q;
        a_word_sx = is_word ? {{(DW-WW){src1_q[WW-1]}}, src1_q[WW-1:0]} : src1_q;
        sign_a    = is_signed & a_ext[DW-1];
        sign_b    = is_signed & b_ext[DW-1];
        abs_a     = sign_a ? (~a_ext + 1'b1) : a_ext;
        abs_b     = sign_b ? (~b_ext + 1'b1) : b_ext;
        min_val   = is_word ? {{(DW-WW+1){1'b1}}, {(WW-1){1'b0}}} : {1'b1, {(DW-1){1'b0}}};
        div_zero  = (b_ext == '0);
        sgn_ovf   = is_signed & (a_ext == min_val) & (b_ext == '1);
    end

    // One restoring step: shift {rem, quo} left and keep the trial difference when non-negative.
    logic [DW:0] shifted, trial;
    always_comb begin
        shifted = {rem_q, quo_q[DW-1]};
        trial   = shifted - {1'b0, dvsr_q};
    end

    // Sign fix-up, quotient/remainder select, word sign-extension, then special-case override.
    logic [DW-1:0] q_fix, r_fix, sel, fix_val;
    always_comb begin
        q_fix = (sign_a ^ sign_b) ? (~quo_q + 1'b1) : quo_q;
        r_fix = sign_a ? (~rem_q + 1'b1) : rem_q;
        sel   = is_rem ? r_fix : q_fix;
        fix_val = is_word ? {{(DW-WW){sel[WW-1]}}, sel[WW-1:0]} : sel;
        if (!is_legal) begin
            fix_val = '0;
        end else if (div_zero) begin
            fix_val = is_rem ? a_word_sx : '1;
        end else if (sgn_ovf) begin
            fix_val = is_rem ? '0 : a_ext;
        end
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    // FSM: next state; flush wins over accept and over the result handshake.
    always_comb begin
        state_d = state_q;
        if (bus.i_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bus.i_valid) state_d = S_PREP;
                S_PREP: begin
`ifdef DIV_EARLY_OUT_EN
                    state_d = (div_zero | sgn_ovf) ? S_FIX : S_CALC;
`else
                    state_d = S_CALC;
`endif
                end
                S_CALC: if (cnt_q == '0) state_d = S_FIX;
                S_FIX:  state_d = S_DONE;
                S_DONE: if (bus.i_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM: outputs decoded from registers only
    always_comb begin
        bus.o_ready  = (state_q == S_IDLE);
        bus.o_valid  = (state_q == S_DONE);
        bus.o_state  = state_q;
        bus.o_result = result_q;
    end

    // Datapath next-state
    always_comb begin
        op_d     = op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_valid && !bus.i_flush) begin
                    op_d   = bus.i_alu_control;
                    src1_d = bus.i_src_1;
                    src2_d = bus.i_src_2;
                end
            end
            S_PREP: begin
                // Word dividends sit in the top half so WW shifts drain them fully.
                quo_d  = is_word ? {abs_a[WW-1:0], {(DW-WW){1'b0}}} : abs_a;
                rem_d  = '0;
                dvsr_d = abs_b;
                cnt_d  = is_word ? CNT_W'(WW-1) : CNT_W'(DW-1);
            end
            S_CALC: begin
                if (!trial[DW]) begin
                    rem_d = trial[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b1};
                end else begin
                    rem_d = shifted[DW-1:0];
                    quo_d = {quo_q[DW-2:0], 1'b0};
                end
                cnt_d = cnt_q - 1'b1;
            end
            S_FIX:   result_d = fix_val;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            op_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvsr_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            op_q     <= op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end
endmodule
